// File: rtl/avmm_host_master_if.sv
// Host byte channel (rx/tx) and Avalon-MM master signals of avmm_host_master.
interface avmm_host_master_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        m_read;
    logic        m_write;
    logic [7:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, m_readdata,
        output rx_ready, tx_valid, tx_data, m_read, m_write, m_address, m_writedata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, m_readdata,
        input  rx_ready, tx_valid, tx_data, m_read, m_write, m_address, m_writedata
    );
endinterface

// File: rtl/avmm_host_master.sv
// Byte-stream command master: framed write/read/poll commands from a host byte
// channel become single-cycle Avalon-MM transactions with byte responses.
module avmm_host_master #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_GAP     = 16,
    parameter int unsigned POLL_MAX     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    avmm_host_master_if.master bus,
    output logic               busy,
    output logic               err_opcode
);
    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_ADDR          = 3'd1;
    localparam logic [2:0] S_WDATA         = 3'd2;
    localparam logic [2:0] S_WR_ISSUE      = 3'd3;
    localparam logic [2:0] S_RD_ISSUE      = 3'd4;
    localparam logic [2:0] S_RD_WAIT       = 3'd5;
    localparam logic [2:0] S_POLL_GAP_WAIT = 3'd6;
    localparam logic [2:0] S_TX            = 3'd7;

    localparam logic [7:0]  OP_WRITE  = 8'h01;
    localparam logic [7:0]  OP_READ   = 8'h02;
    localparam logic [7:0]  OP_POLL   = 8'h03;
    localparam logic [2:0]  LAT_LAST  = 3'(READ_LATENCY - 1);
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP);
    localparam logic [15:0] POLL_LAST = 16'(POLL_MAX);

    logic [2:0]  state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic        is_poll_q, is_poll_d;
    logic [1:0]  wb_idx_q, wb_idx_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [23:0] tx_rest_q, tx_rest_d;
    logic [1:0]  tx_left_q, tx_left_d;

    logic rx_ready;
    logic rx_acc;
    logic tx_acc;

    assign rx_ready = !rst && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_WDATA);
    assign rx_acc   = bus.rx_valid && rx_ready;
    assign tx_acc   = (state_q == S_TX) && bus.tx_ready;

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        is_poll_d  = is_poll_q;
        wb_idx_d   = wb_idx_q;
        lat_cnt_d  = lat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_byte_d  = tx_byte_q;
        tx_rest_d  = tx_rest_q;
        tx_left_d  = tx_left_q;
        err_opcode = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_acc) begin
                    case (bus.rx_data)
                        OP_WRITE: begin is_wr_d = 1'b1; is_poll_d = 1'b0; state_d = S_ADDR; end
                        OP_READ:  begin is_wr_d = 1'b0; is_poll_d = 1'b0; state_d = S_ADDR; end
                        OP_POLL: begin
                            is_wr_d    = 1'b0;
                            is_poll_d  = 1'b1;
                            poll_cnt_d = '0;
                            state_d    = S_ADDR;
                        end
                        default:  err_opcode = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_acc) begin
                    addr_d = bus.rx_data;
                    if (is_wr_q) begin
                        wb_idx_d = '0;
                        state_d  = S_WDATA;
                    end else begin
                        state_d  = S_RD_ISSUE;
                    end
                end
            end
            S_WDATA: begin
                if (rx_acc) begin
                    wdata_d[{wb_idx_q, 3'b000} +: 8] = bus.rx_data;
                    wb_idx_d = wb_idx_q + 2'd1;
                    if (wb_idx_q == 2'd3) state_d = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                tx_byte_d = 8'hA5;
                tx_left_d = '0;
                state_d   = S_TX;
            end
            S_RD_ISSUE: begin
                lat_cnt_d = '0;
                if (is_poll_q) poll_cnt_d = poll_cnt_q + 16'd1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    if (!is_poll_q) begin
                        tx_byte_d = bus.m_readdata[7:0];
                        tx_rest_d = bus.m_readdata[31:8];
                        tx_left_d = 2'd3;
                        state_d   = S_TX;
                    end else if (bus.m_readdata[0]) begin
                        tx_byte_d = 8'h00;
                        tx_left_d = '0;
                        state_d   = S_TX;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        tx_byte_d = 8'hFF;
                        tx_left_d = '0;
                        state_d   = S_TX;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = S_POLL_GAP_WAIT;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_POLL_GAP_WAIT: begin
                // Counts 0..POLL_GAP so poll reads land READ_LATENCY+POLL_GAP+2 apart.
                if (gap_cnt_q == GAP_LAST) state_d = S_RD_ISSUE;
                else                       gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_TX: begin
                if (tx_acc) begin
                    if (tx_left_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_byte_d = tx_rest_q[7:0];
                        tx_rest_d = {8'h00, tx_rest_q[23:8]};
                        tx_left_d = tx_left_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            is_poll_q  <= 1'b0;
            wb_idx_q   <= '0;
            lat_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_byte_q  <= '0;
            tx_rest_q  <= '0;
            tx_left_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            is_poll_q  <= is_poll_d;
            wb_idx_q   <= wb_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_byte_q  <= tx_byte_d;
            tx_rest_q  <= tx_rest_d;
            tx_left_q  <= tx_left_d;
        end
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.tx_valid    = (state_q == S_TX);
    assign bus.tx_data     = tx_byte_q;
    assign bus.m_read      = (state_q == S_RD_ISSUE);
    assign bus.m_write     = (state_q == S_WR_ISSUE);
    assign bus.m_address   = addr_q;
    assign bus.m_writedata = wdata_q;
    assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_avmm_host_master.sv
// Directed and randomized checks of avmm_host_master against a slave model and
// an expected-memory/response model kept in the bench.
module tb_avmm_host_master;
    localparam int RL   = 2;
    localparam int GAP  = 4;
    localparam int PMAX = 5;
    localparam logic [7:0] STATUS_ADDR = 8'h30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err_opcode;

    avmm_host_master_if bus();

    avmm_host_master #(.READ_LATENCY(RL), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_opcode(err_opcode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // ---------------- slave model ----------------
    bit [31:0] smem [256];
    bit [31:0] emem [256];
    bit [31:0] pipe_d [RL];
    bit        pipe_v [RL];
    bit [31:0] garbage;
    int        status_reads = 0;
    int        poll_base = 0;
    int        done_after = 1;

    always @(posedge clk) begin
        if (bus.m_write) smem[bus.m_address] <= bus.m_writedata;
        pipe_v[0] <= bus.m_read;
        if (bus.m_address == STATUS_ADDR)
            pipe_d[0] <= {31'd0, (status_reads - poll_base + 1 >= done_after)};
        else
            pipe_d[0] <= smem[bus.m_address];
        if (bus.m_read && bus.m_address == STATUS_ADDR) status_reads <= status_reads + 1;
        for (int i = 1; i < RL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        garbage <= $urandom;
    end
    assign bus.m_readdata = pipe_v[RL-1] ? pipe_d[RL-1] : garbage;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0, wr_cnt = 0, both_hi = 0, err_cnt = 0, err_cyc = -1;
    int hold_viol = 0, overlap = 0, wr_cyc = -1;
    int rd_cyc [$];
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_tx;

    always @(negedge clk) begin
        if (bus.m_read) begin rd_cnt++; rd_cyc.push_back(cyc); end
        if (bus.m_write) begin wr_cnt++; wr_cyc = cyc; wr_addr = bus.m_address; wr_data = bus.m_writedata; end
        if (bus.m_read && bus.m_write) both_hi++;
        if (bus.rx_ready && bus.tx_valid) overlap++;
        if (err_opcode) begin err_cnt++; err_cyc = cyc; end
        if (prev_hold && bus.tx_valid && bus.tx_data !== prev_tx) hold_viol++;
        prev_hold = bus.tx_valid && !bus.tx_ready;
        prev_tx   = bus.tx_data;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.rx_ready) begin got = 1'b1; acc = cyc; end
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check("rx_accept", got, 1);
    endtask

    // mode 0: always ready, 1: toggle every cycle, 2: random
    task automatic recv(input int n, input int mode, output logic [31:0] word, output int first_cyc);
        int got;
        got = 0;
        first_cyc = -1;
        word = '0;
        for (int k = 0; k < 400 && got < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = k[0];
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (bus.tx_valid && first_cyc < 0) first_cyc = cyc;
            if (bus.tx_valid && bus.tx_ready) begin
                word[8*got +: 8] = bus.tx_data;
                got++;
            end
        end
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
        check("tx_byte_count", got, n);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check(tag, {busy, bus.tx_valid, bus.rx_ready}, 3'b001);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int mode);
        int acc, fc, w0;
        logic [31:0] resp;
        w0 = wr_cnt;
        send_byte(8'h01, acc);
        send_byte(a, acc);
        send_byte(d[7:0], acc);
        send_byte(d[15:8], acc);
        send_byte(d[23:16], acc);
        send_byte(d[31:24], acc);
        recv(1, mode, resp, fc);
        emem[a] = d;
        check("wr_pulses", wr_cnt - w0, 1);
        check("wr_cycle", wr_cyc, acc + 1);
        check("wr_addr", wr_addr, a);
        check("wr_data", wr_data, d);
        check("wr_resp", resp[7:0], 8'hA5);
        check("wr_tx_cycle", fc, acc + 2);
        idle_check("wr_idle");
    endtask

    task automatic do_read(input logic [7:0] a, input int mode);
        int acc, fc, r0;
        logic [31:0] resp;
        r0 = rd_cnt;
        send_byte(8'h02, acc);
        send_byte(a, acc);
        recv(4, mode, resp, fc);
        check("rd_pulses", rd_cnt - r0, 1);
        if (rd_cnt > r0) check("rd_cycle", rd_cyc[r0], acc + 1);
        check("rd_data", resp, emem[a]);
        check("rd_tx_cycle", fc, acc + 2 + RL);
        idle_check("rd_idle");
    endtask

    task automatic do_poll(input int da, input int mode);
        int acc, fc, r0, exp_n, n;
        logic [31:0] resp;
        r0 = rd_cnt;
        poll_base = status_reads;
        done_after = da;
        send_byte(8'h03, acc);
        send_byte(STATUS_ADDR, acc);
        recv(1, mode, resp, fc);
        exp_n = (da <= PMAX) ? da : PMAX;
        check("poll_reads", rd_cnt - r0, exp_n);
        n = (rd_cnt - r0 < exp_n) ? rd_cnt - r0 : exp_n;
        if (n > 0) begin
            check("poll_first_rd", rd_cyc[r0], acc + 1);
            for (int i = 1; i < n; i++)
                check("poll_spacing", rd_cyc[r0+i] - rd_cyc[r0+i-1], RL + GAP + 2);
            check("poll_tx_cycle", fc, rd_cyc[r0+n-1] + RL + 1);
        end
        check("poll_resp", resp[7:0], (da <= PMAX) ? 8'h00 : 8'hFF);
        idle_check("poll_idle");
    endtask

    task automatic do_bad(input logic [7:0] op);
        int acc, e0, r0;
        e0 = err_cnt;
        r0 = rd_cnt;
        send_byte(op, acc);
        @(negedge clk);
        check("bad_op_state", {busy, bus.rx_ready, err_opcode}, 3'b010);
        @(posedge clk); #1;
        check("bad_op_pulses", err_cnt - e0, 1);
        check("bad_op_cycle", err_cyc, acc);
        check("bad_op_no_read", rd_cnt, r0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, w0, op, mode;
        bit seen;
        logic [7:0] a;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b0;

        @(posedge clk); #1;
        check("reset_outputs", {bus.rx_ready, bus.tx_valid, bus.m_read, bus.m_write, busy,
                                err_opcode, bus.m_address, bus.m_writedata, bus.tx_data}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_reset", bus.rx_ready, 1);
        @(posedge clk); #1;

        do_write(8'h10, 32'h12345678, 0);
        do_write(8'h20, 32'hCAFEBABE, 2);
        do_read(8'h20, 1);
        do_poll(3, 0);
        do_poll(1000, 2);
        do_poll(PMAX, 1);

        do_bad(8'h7F);
        do_read(8'h00, 2);

        // reset in the middle of a write frame
        w0 = wr_cnt;
        send_byte(8'h01, acc);
        send_byte(8'h10, acc);
        send_byte(8'hAA, acc);
        #2 rst = 1'b1;
        #1 check("rst_mid_frame", {busy, bus.rx_ready, bus.m_write, bus.tx_valid}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_mid_rst", bus.rx_ready, 1);
        @(posedge clk); #1;
        do_read(8'h10, 0);
        check("no_write_after_rst", wr_cnt, w0);

        // reset while a response is pending
        send_byte(8'h02, acc);
        send_byte(8'h20, acc);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.tx_valid;
        end
        check("tx_before_rst", seen, 1);
        #1 rst = 1'b1;
        #1 check("rst_mid_tx", {bus.tx_valid, busy, bus.m_read}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("idle_after_tx_rst");

        for (int it = 0; it < 24; it++) begin
            op   = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            do a = 8'($urandom); while (a == STATUS_ADDR);
            case (op)
                0: do_write(a, $urandom, mode);
                1: do_read(a, mode);
                2: do_poll($urandom_range(1, PMAX + 2), mode);
                default: begin
                    do a = 8'($urandom); while (a >= 8'h01 && a <= 8'h03);
                    do_bad(a);
                end
            endcase
        end

        check("never_read_and_write", both_hi, 0);
        check("tx_hold_stable", hold_viol, 0);
        check("half_duplex", overlap, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
